// File: rtl/idma_obi_checker.sv
`default_nettype none
// ============================================================================
//  Module      : idma_obi_checker
//  Description : Passive protocol checker for one or more OBI manager ports.
//                Per channel it tracks the outstanding transaction count,
//                holds the address phase of a stalled request, and raises
//                sticky violation flags with a saturating violation-cycle
//                counter. A registered interrupt ORs all flags together.
//
//  Ports (channel c occupies slice [c*W +: W] of every per-channel bus):
//    clk_i          rising-edge clock
//    rst_i          asynchronous active-high reset
//    a_req_i        address-phase request       (1 per channel)
//    a_gnt_i        address-phase grant         (1 per channel)
//    a_we_i         write enable                (1 per channel)
//    a_addr_i       address                     (AddrWidth per channel)
//    a_be_i         byte enables                (DataWidth/8 per channel)
//    a_wdata_i      write data                  (DataWidth per channel)
//    r_valid_i      response valid              (1 per channel)
//    r_ready_i      response ready              (1 per channel)
//    r_rdata_i      response data               (DataWidth per channel)
//    clear_i        clears flags and count      (1 per channel)
//    err_o          sticky flags                (5 per channel)
//                     [0] STABLE_A  [1] RETRACT_A  [2] STABLE_R
//                     [3] ORPHAN_R  [4] OVERFLOW
//    err_cnt_o      saturating violation-cycle count (8 per channel)
//    outstanding_o  outstanding transactions    (OutW per channel)
//    irq_o          registered OR of all err_o bits
//
//  Revision    : 1.0 - initial release
// ============================================================================
module idma_obi_checker #(
   parameter int NumChannels    = 1,
   parameter int AddrWidth      = 32,
   parameter int DataWidth      = 32,
   parameter int MaxOutstanding = 4,
   localparam int OutW          = $clog2(MaxOutstanding + 1),
   localparam int BeW           = DataWidth / 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumChannels-1:0]         a_req_i,
   input  logic [NumChannels-1:0]         a_gnt_i,
   input  logic [NumChannels-1:0]         a_we_i,
   input  logic [NumChannels*AddrWidth-1:0] a_addr_i,
   input  logic [NumChannels*BeW-1:0]     a_be_i,
   input  logic [NumChannels*DataWidth-1:0] a_wdata_i,
   input  logic [NumChannels-1:0]         r_valid_i,
   input  logic [NumChannels-1:0]         r_ready_i,
   input  logic [NumChannels*DataWidth-1:0] r_rdata_i,
   input  logic [NumChannels-1:0]         clear_i,
   output logic [NumChannels*5-1:0]       err_o,
   output logic [NumChannels*8-1:0]       err_cnt_o,
   output logic [NumChannels*OutW-1:0]    outstanding_o,
   output logic                           irq_o
);

   localparam logic [OutW-1:0] MaxCnt = OutW'(MaxOutstanding);

   // Low during reset and for the first cycle after release, so nothing can
   // be flagged before the monitored bus has had one clean cycle.
   logic r_active;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_active <= 1'b0;
      end else begin
         r_active <= 1'b1;
      end
   end

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      // Per-channel views of the flattened buses
      logic                 a_req, a_gnt, a_we, r_valid, r_ready, clear;
      logic [AddrWidth-1:0] a_addr;
      logic [BeW-1:0]       a_be;
      logic [DataWidth-1:0] a_wdata, r_rdata;

      assign a_req   = a_req_i[c];
      assign a_gnt   = a_gnt_i[c];
      assign a_we    = a_we_i[c];
      assign r_valid = r_valid_i[c];
      assign r_ready = r_ready_i[c];
      assign clear   = clear_i[c];
      assign a_addr  = a_addr_i[c*AddrWidth +: AddrWidth];
      assign a_be    = a_be_i[c*BeW +: BeW];
      assign a_wdata = a_wdata_i[c*DataWidth +: DataWidth];
      assign r_rdata = r_rdata_i[c*DataWidth +: DataWidth];

      // State
      logic                 r_pending;
      logic                 r_cap_we;
      logic [AddrWidth-1:0] r_cap_addr;
      logic [BeW-1:0]       r_cap_be;
      logic [DataWidth-1:0] r_cap_wdata;
      logic                 r_rsp_stall;
      logic [DataWidth-1:0] r_rsp_data;
      logic [OutW-1:0]      r_cnt;
      logic [4:0]           r_err;
      logic [7:0]           r_err_cnt;

      logic                 w_a_hs;
      logic                 w_r_hs;
      logic                 w_a_diff;
      logic [4:0]           w_viol;
      logic                 w_any;

      assign w_a_hs = a_req && a_gnt;
      assign w_r_hs = r_valid && r_ready;

      always_comb begin
         w_a_diff = 1'b0;
         w_viol   = 5'b0;

         // Write data only matters when the held request is a write.
         w_a_diff = (a_we != r_cap_we) || (a_addr != r_cap_addr) ||
                    (a_be != r_cap_be) ||
                    (r_cap_we && (a_wdata != r_cap_wdata));

         // A dropped request is reported as a retract only, never also as
         // an unstable address phase.
         w_viol[1] = r_pending && !a_req;
         w_viol[0] = r_pending && a_req && w_a_diff && !w_viol[1];
         w_viol[2] = r_rsp_stall && (!r_valid || (r_rdata != r_rsp_data));
         w_viol[3] = w_r_hs && (r_cnt == '0) && !w_a_hs;
         w_viol[4] = w_a_hs && (r_cnt == MaxCnt) && !w_r_hs;

         if (!r_active) begin
            w_viol = 5'b0;
         end
      end

      assign w_any = |w_viol;

      // Address-phase capture and response-stall tracking
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_pending   <= 1'b0;
            r_cap_we    <= 1'b0;
            r_cap_addr  <= '0;
            r_cap_be    <= '0;
            r_cap_wdata <= '0;
            r_rsp_stall <= 1'b0;
            r_rsp_data  <= '0;
         end else begin
            r_pending   <= a_req && !a_gnt;
            if (a_req && !a_gnt) begin
               r_cap_we    <= a_we;
               r_cap_addr  <= a_addr;
               r_cap_be    <= a_be;
               r_cap_wdata <= a_wdata;
            end
            r_rsp_stall <= r_valid && !r_ready;
            if (r_valid && !r_ready) begin
               r_rsp_data <= r_rdata;
            end
         end
      end

      // Outstanding count: a grant and a completion in the same cycle cancel.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_cnt <= '0;
         end else if (w_a_hs && !w_r_hs) begin
            if (r_cnt != MaxCnt) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else if (w_r_hs && !w_a_hs) begin
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end

      // Sticky flags and violation-cycle counter. A clear restarts both from
      // whatever this cycle detects, so a coincident violation is not lost.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_err     <= 5'b0;
            r_err_cnt <= 8'd0;
         end else if (clear) begin
            r_err     <= w_viol;
            r_err_cnt <= w_any ? 8'd1 : 8'd0;
         end else begin
            r_err <= r_err | w_viol;
            if (w_any && (r_err_cnt != 8'hFF)) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end
      end

      assign err_o[c*5 +: 5]            = r_err;
      assign err_cnt_o[c*8 +: 8]        = r_err_cnt;
      assign outstanding_o[c*OutW +: OutW] = r_cnt;
   end

   // Interrupt follows the flags by one cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= |err_o;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_idma_obi_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idma_obi_checker
//  Description : Directed self-checking bench for idma_obi_checker with two
//                channels and four legal outstanding transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idma_obi_checker;

   localparam int NCH  = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXO = 4;
   localparam int OW   = $clog2(MAXO + 1);

   logic                 clk;
   logic                 rst;
   logic [NCH-1:0]       a_req, a_gnt, a_we, r_valid, r_ready, clear;
   logic [NCH*AW-1:0]    a_addr;
   logic [NCH*DW/8-1:0]  a_be;
   logic [NCH*DW-1:0]    a_wdata, r_rdata;
   logic [NCH*5-1:0]     err;
   logic [NCH*8-1:0]     err_cnt;
   logic [NCH*OW-1:0]    outstanding;
   logic                 irq;

   int n_vec = 0;
   int n_mis = 0;

   idma_obi_checker #(
      .NumChannels   (NCH),
      .AddrWidth     (AW),
      .DataWidth     (DW),
      .MaxOutstanding(MAXO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .a_req_i      (a_req),
      .a_gnt_i      (a_gnt),
      .a_we_i       (a_we),
      .a_addr_i     (a_addr),
      .a_be_i       (a_be),
      .a_wdata_i    (a_wdata),
      .r_valid_i    (r_valid),
      .r_ready_i    (r_ready),
      .r_rdata_i    (r_rdata),
      .clear_i      (clear),
      .err_o        (err),
      .err_cnt_o    (err_cnt),
      .outstanding_o(outstanding),
      .irq_o        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; returns 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_req = '0; a_gnt = '0; a_we = '0; r_valid = '0; r_ready = '0; clear = '0;
      a_addr = '0; a_be = '0; a_wdata = '0; r_rdata = '0;
   endtask

   // Reset, release, then let the post-release cycle pass idle.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;

      // ---------------- Scenario 1: stalled read then completion ----------
      do_reset();
      chk("rst_err",   32'(err),         32'h0);
      chk("rst_cnt",   32'(err_cnt),     32'h0);
      chk("rst_out",   32'(outstanding), 32'h0);
      chk("rst_irq",   32'(irq),         32'h0);

      a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[31:0] = 32'h100; a_be[3:0] = 4'hF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s1_wait_out0", 32'(outstanding[OW-1:0]), 32'd0);
      end
      a_gnt[0] = 1'b1;
      step();
      chk("s1_gnt_out0", 32'(outstanding[OW-1:0]), 32'd1);
      a_req[0] = 1'b0; a_gnt[0] = 1'b0; r_valid[0] = 1'b1; r_ready[0] = 1'b1;
      step();
      chk("s1_rsp_out0", 32'(outstanding[OW-1:0]), 32'd0);
      r_valid[0] = 1'b0; r_ready[0] = 1'b0;
      step();
      chk("s1_err", 32'(err), 32'h0);
      chk("s1_irq", 32'(irq), 32'h0);

      // ---------------- Scenario 2: unstable write data -------------------
      do_reset();
      a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[31:0] = 32'h200; a_be[3:0] = 4'hF;
      a_wdata[31:0] = 32'hA5;
      step();
      a_wdata[31:0] = 32'h5A;
      step();
      chk("s2_err0",    32'(err[4:0]),      32'b00001);
      chk("s2_cnt0",    32'(err_cnt[7:0]),  32'd1);
      chk("s2_irq_lag", 32'(irq),           32'h0);
      a_gnt[0] = 1'b1;
      step();
      chk("s2_irq",   32'(irq),                  32'h1);
      chk("s2_cnt0b", 32'(err_cnt[7:0]),         32'd1);
      chk("s2_out0",  32'(outstanding[OW-1:0]),  32'd1);
      chk("s2_err1",  32'(err[9:5]),             32'h0);
      chk("s2_cnt1",  32'(err_cnt[15:8]),        32'd0);
      chk("s2_out1",  32'(outstanding[2*OW-1:OW]), 32'd0);
      a_req[0] = 1'b0; a_gnt[0] = 1'b0;

      // ---------------- Scenario 3: orphan response, overflow -------------
      do_reset();
      r_valid[1] = 1'b1; r_ready[1] = 1'b1;
      step();
      chk("s3_orphan_err1", 32'(err[9:5]),               32'b01000);
      chk("s3_orphan_out1", 32'(outstanding[2*OW-1:OW]), 32'd0);
      r_valid[1] = 1'b0; r_ready[1] = 1'b0;
      a_req[1] = 1'b1; a_gnt[1] = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("s3_full_out1", 32'(outstanding[2*OW-1:OW]), 32'd4);
      chk("s3_full_err1", 32'(err[9:5]),               32'b01000);
      step();
      chk("s3_ovf_err1",  32'(err[9:5]),               32'b11000);
      chk("s3_ovf_out1",  32'(outstanding[2*OW-1:OW]), 32'd4);
      chk("s3_ovf_cnt1",  32'(err_cnt[15:8]),          32'd2);
      chk("s3_err0",      32'(err[4:0]),               32'h0);
      a_req[1] = 1'b0; a_gnt[1] = 1'b0;

      // ---------------- Scenario 4: dropped response, clear + retract -----
      do_reset();
      r_valid[0] = 1'b1; r_ready[0] = 1'b0; r_rdata[31:0] = 32'h33;
      step();
      r_valid[0] = 1'b0;
      step();
      chk("s4_stable_r", 32'(err[4:0]),     32'b00100);
      chk("s4_cnt",      32'(err_cnt[7:0]), 32'd1);
      a_req[0] = 1'b1; a_addr[31:0] = 32'h300; a_be[3:0] = 4'h3;
      step();
      a_req[0] = 1'b0; clear[0] = 1'b1;
      step();
      clear[0] = 1'b0;
      chk("s4_clr_err", 32'(err[4:0]),     32'b00010);
      chk("s4_clr_cnt", 32'(err_cnt[7:0]), 32'd1);

      // ---------------- Scenario 5: counter saturation --------------------
      do_reset();
      r_valid[0] = 1'b1; r_ready[0] = 1'b1;
      for (int i = 0; i < 254; i++) step();
      chk("s5_cnt254", 32'(err_cnt[7:0]), 32'd254);
      for (int i = 0; i < 46; i++) step();
      chk("s5_cnt_sat", 32'(err_cnt[7:0]), 32'd255);
      chk("s5_err",     32'(err[4:0]),     32'b01000);
      r_valid[0] = 1'b0; r_ready[0] = 1'b0;

      // ---------------- Scenario 6: asynchronous reset mid-traffic --------
      do_reset();
      a_req[0] = 1'b1; a_gnt[0] = 1'b1; r_valid[1] = 1'b1; r_ready[1] = 1'b1;
      step();
      r_valid[1] = 1'b0; r_ready[1] = 1'b0;
      step();
      chk("s6_pre_out0", 32'(outstanding[OW-1:0]), 32'd2);
      chk("s6_pre_err1", 32'(err[9:5]),            32'b01000);
      chk("s6_pre_irq",  32'(irq),                 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("s6_rst_out", 32'(outstanding), 32'h0);
      chk("s6_rst_err", 32'(err),         32'h0);
      chk("s6_rst_cnt", 32'(err_cnt),     32'h0);
      chk("s6_rst_irq", 32'(irq),         32'h0);
      a_req[0] = 1'b0; a_gnt[0] = 1'b0; r_valid[1] = 1'b1; r_ready[1] = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      step();
      chk("s6_post_err", 32'(err),     32'h0);
      chk("s6_post_cnt", 32'(err_cnt), 32'h0);
      r_valid[1] = 1'b0; r_ready[1] = 1'b0;
      step();
      chk("s6_post_irq", 32'(irq),         32'h0);
      chk("s6_post_out", 32'(outstanding), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
